// File: rtl/ninja_disp_pkg.sv
// Shared display constants for the NinjaReflex 7-segment drivers.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package ninja_disp_pkg;

  localparam int CODE_W = 5;

  // Non-hex glyph codes; 0x00-0x0F are plain hex digits.
  localparam logic [CODE_W-1:0] CODE_BLANK     = 5'h10;
  localparam logic [CODE_W-1:0] CODE_DASH      = 5'h11;
  localparam logic [CODE_W-1:0] CODE_ACT_UP    = 5'h12;
  localparam logic [CODE_W-1:0] CODE_ACT_DOWN  = 5'h13;
  localparam logic [CODE_W-1:0] CODE_ACT_LEFT  = 5'h14;
  localparam logic [CODE_W-1:0] CODE_ACT_RIGHT = 5'h15;
  localparam logic [CODE_W-1:0] CODE_ALL       = 5'h1F;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_ALL = 8'h00;

endpackage

// File: rtl/seg_decoder.sv
// Combinational glyph decoder: 5-bit display code plus decimal point to an
// active-low {dp,g,f,e,d,c,b,a} pattern. Unknown codes decode to blank.
module seg_decoder
  import ninja_disp_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              dp_i,
  output logic [7:0]        seg_o
);

  logic [7:0] pat;

  // Look up the glyph, then clear bit 7 when the decimal point is lit.
  always_comb begin
    pat = SEG_OFF;
    case (code_i)
      5'h00:          pat = 8'hC0;
      5'h01:          pat = 8'hF9;
      5'h02:          pat = 8'hA4;
      5'h03:          pat = 8'hB0;
      5'h04:          pat = 8'h99;
      5'h05:          pat = 8'h92;
      5'h06:          pat = 8'h82;
      5'h07:          pat = 8'hF8;
      5'h08:          pat = 8'h80;
      5'h09:          pat = 8'h90;
      5'h0A:          pat = 8'h88;
      5'h0B:          pat = 8'h83;
      5'h0C:          pat = 8'hC6;
      5'h0D:          pat = 8'hA1;
      5'h0E:          pat = 8'h86;
      5'h0F:          pat = 8'h8E;
      CODE_BLANK:     pat = SEG_OFF;
      CODE_DASH:      pat = 8'hBF;
      CODE_ACT_UP:    pat = 8'hFE;
      CODE_ACT_DOWN:  pat = 8'hF7;
      CODE_ACT_LEFT:  pat = 8'hCF;
      CODE_ACT_RIGHT: pat = 8'hF9;
      CODE_ALL:       pat = SEG_ALL;
      default:        pat = SEG_OFF;
    endcase
    seg_o = dp_i ? {1'b0, pat[6:0]} : pat;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner with anti-ghost dead time,
// frame-synchronous digit updates, per-digit blink and a game-over override.
// Counters describe the slot position being prepared; node/segment/frame_start
// register that position, so they show it one cycle later. Consequently the
// frame boundary (counters at slot 0 of digit 0) is the cycle before frame_start.
// Update handshake: load is a single-cycle strobe with no back-pressure; it
// always lands in staging, and staging moves to shadow only at a frame boundary
// while pending is set, so a frame never mixes old and new digits.
module seg_scan_driver
  import ninja_disp_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 16384,
  parameter int DEAD_CYC     = 64,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_DIGITS*CODE_W-1:0]   digit_code,
  input  logic [N_DIGITS-1:0]          digit_dp,
  input  logic [N_DIGITS-1:0]          blink_mask,
  input  logic                         load,
  input  logic                         force_all,
  output logic [N_DIGITS-1:0]          node,
  output logic [7:0]                   segment,
  output logic                         frame_start
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]   DEAD_LIM  = SLOT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] NODE_ONE  = N_DIGITS'(1);

  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FRM_W-1:0]           frm_q, frm_d;
  logic                       blink_on_q, blink_on_d;
  logic                       pending_q, pending_d;
  logic [N_DIGITS*CODE_W-1:0] stg_code_q, stg_code_d, shd_code_q, shd_code_d;
  logic [N_DIGITS-1:0]        stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic [N_DIGITS-1:0]        stg_mask_q, stg_mask_d, shd_mask_q, shd_mask_d;
  logic [N_DIGITS-1:0]        node_q, node_d;
  logic [7:0]                 seg_q, seg_d;
  logic                       fs_q, fs_d;

  logic                       boundary;
  logic                       dead;
  logic [CODE_W-1:0]          cur_code;
  logic                       cur_dp;
  logic                       cur_blink;
  logic [7:0]                 dec_seg;

  seg_decoder u_dec (
    .code_i (cur_code),
    .dp_i   (cur_dp),
    .seg_o  (dec_seg)
  );

  // Next-state for counters, staging/shadow handshake, blink and output pattern.
  always_comb begin
    boundary   = (slot_q == '0) && (idx_q == '0);
    dead       = (slot_q < DEAD_LIM);

    slot_d     = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    idx_d      = idx_q;
    if (slot_q == SLOT_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    frm_d      = frm_q;
    blink_on_d = blink_on_q;
    if (boundary) begin
      if (frm_q == FRM_LAST) begin
        frm_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        frm_d      = frm_q + 1'b1;
      end
    end

    // Shadow takes the staging contents that existed before this cycle's load.
    shd_code_d = shd_code_q;
    shd_dp_d   = shd_dp_q;
    shd_mask_d = shd_mask_q;
    if (boundary && pending_q) begin
      shd_code_d = stg_code_q;
      shd_dp_d   = stg_dp_q;
      shd_mask_d = stg_mask_q;
    end

    stg_code_d = load ? digit_code : stg_code_q;
    stg_dp_d   = load ? digit_dp   : stg_dp_q;
    stg_mask_d = load ? blink_mask : stg_mask_q;
    pending_d  = load ? 1'b1 : (boundary ? 1'b0 : pending_q);

    cur_code   = shd_code_d[int'(idx_q)*CODE_W +: CODE_W];
    cur_dp     = shd_dp_d[idx_q];
    cur_blink  = shd_mask_d[idx_q];

    node_d     = dead ? '1 : ~(NODE_ONE << idx_q);
    if (dead)                          seg_d = SEG_OFF;
    else if (force_all)                seg_d = SEG_ALL;
    else if (cur_blink && !blink_on_d) seg_d = SEG_OFF;
    else                               seg_d = dec_seg;
    fs_d       = boundary;
  end

  // Scan counters and blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      idx_q      <= '0;
      frm_q      <= '0;
      blink_on_q <= 1'b1;
    end else begin
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      frm_q      <= frm_d;
      blink_on_q <= blink_on_d;
    end
  end

  // Staging and shadow registers with the load-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_code_q <= {N_DIGITS{CODE_BLANK}};
      stg_dp_q   <= '0;
      stg_mask_q <= '0;
      shd_code_q <= {N_DIGITS{CODE_BLANK}};
      shd_dp_q   <= '0;
      shd_mask_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      stg_code_q <= stg_code_d;
      stg_dp_q   <= stg_dp_d;
      stg_mask_q <= stg_mask_d;
      shd_code_q <= shd_code_d;
      shd_dp_q   <= shd_dp_d;
      shd_mask_q <= shd_mask_d;
      pending_q  <= pending_d;
    end
  end

  // Output register: anodes, segments and frame pulse change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      node_q <= '1;
      seg_q  <= SEG_OFF;
      fs_q   <= 1'b0;
    end else begin
      node_q <= node_d;
      seg_q  <= seg_d;
      fs_q   <= fs_d;
    end
  end

  assign node        = node_q;
  assign segment     = seg_q;
  assign frame_start = fs_q;

endmodule
